// File: rtl/dds_chan_ctrl.sv
// dds_chan_ctrl: clamps DDS channel parameter writes into per-channel shadows and commits them glitch-free to live outputs.
// Latency: write taken at edge N, clamped in N+1, shadow loaded at end of N+1; live on wrap/commit_all/timeout, or one cycle after the load when sync_en=0.
// Backpressure: wr_ready drops for the single cycle after each accepted write (at most one write per 2 cycles); no other stalls.
//
// Ports: clk/rst (sync, active-high); sync_en, commit_all, phase_wrap[NCH] commit controls;
//        wr_valid/wr_ready + wr_ch/wr_phase/wr_amp/wr_offset/wr_shape write port, wr_err pulse;
//        phase_M/signal_A/signal_off/signal_shape packed live values (channel i at slice i);
//        pending/update per-channel status.
module dds_chan_ctrl #(
  parameter int NCH       = 2,
  parameter int PHASE_W   = 16,
  parameter int AMP_W     = 12,
  parameter int OFF_W     = 12,
  parameter int DAC_MAX   = 4095,
  parameter int DEF_PHASE = 10,
  parameter int DEF_AMP   = 1200,
  parameter int TIMEOUT   = 65535,
  localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sync_en,
  input  logic                   commit_all,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [CH_W-1:0]        wr_ch,
  input  logic [PHASE_W-1:0]     wr_phase,
  input  logic [AMP_W-1:0]       wr_amp,
  input  logic [OFF_W-1:0]       wr_offset,
  input  logic [1:0]             wr_shape,
  input  logic [NCH-1:0]         phase_wrap,
  output logic [NCH*PHASE_W-1:0] phase_M,
  output logic [NCH*AMP_W-1:0]   signal_A,
  output logic [NCH*OFF_W-1:0]   signal_off,
  output logic [NCH*2-1:0]       signal_shape,
  output logic [NCH-1:0]         pending,
  output logic [NCH-1:0]         update,
  output logic                   wr_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PEND = 2'd1, S_COMMIT = 2'd2} state_t;

  // Input register: holds one accepted write for the clamp cycle.
  logic               r_in_vld;
  logic [CH_W-1:0]    r_in_ch;
  logic [PHASE_W-1:0] r_in_phase;
  logic [AMP_W-1:0]   r_in_amp;
  logic [OFF_W-1:0]   r_in_off;
  logic [1:0]         r_in_shape;

  assign wr_ready = ~r_in_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_vld   <= 1'b0;
      r_in_ch    <= '0;
      r_in_phase <= '0;
      r_in_amp   <= '0;
      r_in_off   <= '0;
      r_in_shape <= '0;
    end else begin
      r_in_vld <= wr_valid & ~r_in_vld;
      if (wr_valid & ~r_in_vld) begin
        r_in_ch    <= wr_ch;
        r_in_phase <= wr_phase;
        r_in_amp   <= wr_amp;
        r_in_off   <= wr_offset;
        r_in_shape <= wr_shape;
      end
    end
  end

  // Clamp: done in 32-bit so DAC_MAX - offset never wraps.
  logic [31:0]      w_off_ext;
  logic [31:0]      w_amp_lim;
  logic [OFF_W-1:0] w_off_c;
  logic [AMP_W-1:0] w_amp_c;
  logic [1:0]       w_shape_c;
  logic             w_off_clip, w_amp_clip, w_shape_bad, w_ch_bad;

  assign w_off_ext   = 32'(r_in_off);
  assign w_off_clip  = w_off_ext > 32'(DAC_MAX);
  assign w_off_c     = w_off_clip ? OFF_W'(DAC_MAX) : r_in_off;
  assign w_amp_lim   = 32'(DAC_MAX) - 32'(w_off_c);
  assign w_amp_clip  = 32'(r_in_amp) > w_amp_lim;
  // When clipping, the limit is below r_in_amp so it fits AMP_W.
  assign w_amp_c     = w_amp_clip ? AMP_W'(w_amp_lim) : r_in_amp;
  assign w_shape_bad = (r_in_shape == 2'd3);
  assign w_shape_c   = w_shape_bad ? 2'd0 : r_in_shape;
  assign w_ch_bad    = 32'(r_in_ch) >= 32'(NCH);
  assign wr_err      = r_in_vld & (w_off_clip | w_amp_clip | w_shape_bad | w_ch_bad);

  // Per-channel state.
  state_t             r_state     [NCH];
  state_t             w_state_nxt [NCH];
  logic [CNT_W-1:0]   r_cnt       [NCH];
  logic [PHASE_W-1:0] r_sh_phase  [NCH];
  logic [AMP_W-1:0]   r_sh_amp    [NCH];
  logic [OFF_W-1:0]   r_sh_off    [NCH];
  logic [1:0]         r_sh_shape  [NCH];
  logic [PHASE_W-1:0] r_lv_phase  [NCH];
  logic [AMP_W-1:0]   r_lv_amp    [NCH];
  logic [OFF_W-1:0]   r_lv_off    [NCH];
  logic [1:0]         r_lv_shape  [NCH];
  logic [NCH-1:0]     w_load, w_cond, w_commit, w_bypass;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      w_load[c]      = r_in_vld & ~w_ch_bad & (32'(r_in_ch) == 32'(c));
      w_cond[c]      = phase_wrap[c] | commit_all |
                       ((r_state[c] == S_PEND) & ((r_cnt[c] == CNT_LAST) | ~sync_en));
      w_commit[c]    = 1'b0;
      w_bypass[c]    = 1'b0;
      w_state_nxt[c] = r_state[c];
      if (w_load[c]) begin
        // A commit condition on the load edge takes the fresh values straight to live,
        // so a stale shadow is never exposed.
        if (w_cond[c]) begin
          w_bypass[c]    = 1'b1;
          w_state_nxt[c] = S_COMMIT;
        end else begin
          w_state_nxt[c] = S_PEND;
        end
      end else begin
        case (r_state[c])
          S_IDLE:   w_state_nxt[c] = S_IDLE;
          S_PEND: begin
            if (w_cond[c]) begin
              w_commit[c]    = 1'b1;
              w_state_nxt[c] = S_COMMIT;
            end
          end
          S_COMMIT: w_state_nxt[c] = S_IDLE;
          default:  w_state_nxt[c] = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (rst) begin
        r_state[c]    <= S_IDLE;
        r_cnt[c]      <= '0;
        r_sh_phase[c] <= PHASE_W'(DEF_PHASE);
        r_sh_amp[c]   <= AMP_W'(DEF_AMP);
        r_sh_off[c]   <= '0;
        r_sh_shape[c] <= '0;
        r_lv_phase[c] <= PHASE_W'(DEF_PHASE);
        r_lv_amp[c]   <= AMP_W'(DEF_AMP);
        r_lv_off[c]   <= '0;
        r_lv_shape[c] <= '0;
      end else begin
        r_state[c] <= w_state_nxt[c];
        // Counter only runs while waiting for a wrap; a reload restarts it.
        if (w_load[c] || (r_state[c] != S_PEND)) r_cnt[c] <= '0;
        else if (r_cnt[c] != CNT_LAST)           r_cnt[c] <= r_cnt[c] + CNT_W'(1);
        if (w_load[c]) begin
          r_sh_phase[c] <= r_in_phase;
          r_sh_amp[c]   <= w_amp_c;
          r_sh_off[c]   <= w_off_c;
          r_sh_shape[c] <= w_shape_c;
        end
        if (w_bypass[c]) begin
          r_lv_phase[c] <= r_in_phase;
          r_lv_amp[c]   <= w_amp_c;
          r_lv_off[c]   <= w_off_c;
          r_lv_shape[c] <= w_shape_c;
        end else if (w_commit[c]) begin
          r_lv_phase[c] <= r_sh_phase[c];
          r_lv_amp[c]   <= r_sh_amp[c];
          r_lv_off[c]   <= r_sh_off[c];
          r_lv_shape[c] <= r_sh_shape[c];
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign phase_M[g*PHASE_W +: PHASE_W]  = r_lv_phase[g];
    assign signal_A[g*AMP_W +: AMP_W]     = r_lv_amp[g];
    assign signal_off[g*OFF_W +: OFF_W]   = r_lv_off[g];
    assign signal_shape[g*2 +: 2]         = r_lv_shape[g];
    assign pending[g]                     = (r_state[g] == S_PEND);
    assign update[g]                      = (r_state[g] == S_COMMIT);
  end

endmodule

// File: tb/tb_dds_chan_ctrl.sv
// tb_dds_chan_ctrl: directed and randomized checks of dds_chan_ctrl against a behavioural model.
// Latency: n/a (bench).
// Backpressure: drives writes only when wr_ready is expected high, except in the back-to-back and random scenarios.
module tb_dds_chan_ctrl;
  localparam int NCH = 3, PW = 16, AW = 12, OW = 13, DMAX = 4095, TO = 16, CHW = 2;
  localparam int LW = NCH * (PW + AW + OW + 2);
  localparam int SW = 2 * NCH + 2;

  logic clk = 1'b0, rst = 1'b1, sync_en = 1'b1, commit_all = 1'b0, wr_valid = 1'b0;
  logic wr_ready, wr_err;
  logic [CHW-1:0] wr_ch = '0;
  logic [PW-1:0] wr_phase = '0;
  logic [AW-1:0] wr_amp = '0;
  logic [OW-1:0] wr_offset = '0;
  logic [1:0] wr_shape = '0;
  logic [NCH-1:0] phase_wrap = '0;
  logic [NCH*PW-1:0] phase_M;
  logic [NCH*AW-1:0] signal_A;
  logic [NCH*OW-1:0] signal_off;
  logic [NCH*2-1:0] signal_shape;
  logic [NCH-1:0] pending, update;

  int n_chk = 0, n_pass = 0;

  dds_chan_ctrl #(.NCH(NCH), .PHASE_W(PW), .AMP_W(AW), .OFF_W(OW), .DAC_MAX(DMAX),
                  .DEF_PHASE(10), .DEF_AMP(1200), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .sync_en(sync_en), .commit_all(commit_all),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch), .wr_phase(wr_phase),
    .wr_amp(wr_amp), .wr_offset(wr_offset), .wr_shape(wr_shape), .phase_wrap(phase_wrap),
    .phase_M(phase_M), .signal_A(signal_A), .signal_off(signal_off), .signal_shape(signal_shape),
    .pending(pending), .update(update), .wr_err(wr_err));

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_ph[NCH], m_amp[NCH], m_off[NCH], m_sh[NCH];   // live
  int s_ph[NCH], s_amp[NCH], s_off[NCH], s_sh[NCH];   // shadow
  bit m_pend[NCH], m_upd[NCH];
  longint m_load_edge[NCH];
  longint m_edge = 0;
  bit q_vld = 0, q_err = 0;
  int q_ch, q_ph, q_amp, q_off, q_sh;
  bit ld, cond;

  always @(posedge clk) begin
    m_edge++;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_ph[c] = 10; m_amp[c] = 1200; m_off[c] = 0; m_sh[c] = 0;
        s_ph[c] = 10; s_amp[c] = 1200; s_off[c] = 0; s_sh[c] = 0;
        m_pend[c] = 0; m_upd[c] = 0; m_load_edge[c] = 0;
      end
      q_vld = 0; q_err = 0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        ld   = q_vld && (q_ch == c);
        // Pending channel times out TO edges after the edge that loaded it.
        cond = phase_wrap[c] || commit_all ||
               (m_pend[c] && (!sync_en || (m_edge - m_load_edge[c] == TO)));
        m_upd[c] = 0;
        if (ld) begin
          s_ph[c] = q_ph; s_amp[c] = q_amp; s_off[c] = q_off; s_sh[c] = q_sh;
          if (cond) begin
            m_ph[c] = q_ph; m_amp[c] = q_amp; m_off[c] = q_off; m_sh[c] = q_sh;
            m_upd[c] = 1; m_pend[c] = 0;
          end else begin
            m_pend[c] = 1; m_load_edge[c] = m_edge;
          end
        end else if (m_pend[c] && cond) begin
          m_ph[c] = s_ph[c]; m_amp[c] = s_amp[c]; m_off[c] = s_off[c]; m_sh[c] = s_sh[c];
          m_upd[c] = 1; m_pend[c] = 0;
        end
      end
      if (q_vld) q_vld = 0;
      else if (wr_valid) begin
        int off_raw, amp_raw, lim;
        off_raw = int'(wr_offset);
        amp_raw = int'(wr_amp);
        q_off = (off_raw > DMAX) ? DMAX : off_raw;
        lim   = DMAX - q_off;
        q_amp = (amp_raw > lim) ? lim : amp_raw;
        q_sh  = (wr_shape == 2'd3) ? 0 : int'(wr_shape);
        q_ph  = int'(wr_phase);
        q_ch  = int'(wr_ch);
        q_err = (off_raw > DMAX) || (amp_raw > lim) || (wr_shape == 2'd3) || (q_ch >= NCH);
        q_vld = 1;
      end
    end
  end

  function automatic logic [LW-1:0] e_live();
    logic [NCH*PW-1:0] p; logic [NCH*AW-1:0] a; logic [NCH*OW-1:0] o; logic [NCH*2-1:0] s;
    for (int c = 0; c < NCH; c++) begin
      p[c*PW +: PW] = PW'(m_ph[c]);
      a[c*AW +: AW] = AW'(m_amp[c]);
      o[c*OW +: OW] = OW'(m_off[c]);
      s[c*2 +: 2]   = 2'(m_sh[c]);
    end
    return {p, a, o, s};
  endfunction

  function automatic logic [SW-1:0] e_stat();
    logic [NCH-1:0] p, u;
    for (int c = 0; c < NCH; c++) begin p[c] = m_pend[c]; u[c] = m_upd[c]; end
    return {p, u, q_vld & q_err, ~q_vld};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Presents one write for one cycle; returns in cycle N+1.
  task automatic do_write(input int ch, input int ph, input int amp, input int off, input int sh);
    wr_valid = 1'b1; wr_ch = CHW'(ch); wr_phase = PW'(ph); wr_amp = AW'(amp);
    wr_offset = OW'(off); wr_shape = 2'(sh);
    cyc();
    wr_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    n_chk++; if (phase_M !== {NCH{16'd10}}) $display("FAIL reset_phase: got %h want %h", phase_M, {NCH{16'd10}}); else n_pass++;
    n_chk++; if (signal_A !== {NCH{12'd1200}}) $display("FAIL reset_amp: got %h want %h", signal_A, {NCH{12'd1200}}); else n_pass++;
    n_chk++; if ({signal_off, signal_shape} !== '0) $display("FAIL reset_off_shape: got %h want 0", {signal_off, signal_shape}); else n_pass++;
    n_chk++; if ({pending, update, wr_err, wr_ready} !== {{2*NCH{1'b0}}, 2'b01})
      $display("FAIL reset_status: got %b want %b", {pending, update, wr_err, wr_ready}, {{2*NCH{1'b0}}, 2'b01}); else n_pass++;
  endtask

  task automatic test_basic();
    sync_en = 1'b1;
    do_write(1, 500, 1000, 2000, 1);
    n_chk++; if (wr_ready !== 1'b0) $display("FAIL basic_ready_low: got %b want 0", wr_ready); else n_pass++;
    cyc();
    n_chk++; if ({pending[1], wr_ready} !== 2'b11) $display("FAIL basic_pending: got %b want 11", {pending[1], wr_ready}); else n_pass++;
    repeat (10) cyc();
    n_chk++; if ({pending[1], signal_A[AW +: AW]} !== {1'b1, 12'd1200})
      $display("FAIL basic_hold: got %h want %h", {pending[1], signal_A[AW +: AW]}, {1'b1, 12'd1200}); else n_pass++;
    phase_wrap = 3'b010;
    cyc();
    phase_wrap = '0;
    n_chk++; if ({update, pending} !== {3'b010, 3'b000}) $display("FAIL basic_update: got %b want 010000", {update, pending}); else n_pass++;
    n_chk++; if ({phase_M[PW +: PW], signal_A[AW +: AW], signal_off[OW +: OW], signal_shape[3:2]} !== {16'd500, 12'd1000, 13'd2000, 2'd1})
      $display("FAIL basic_live: got %h want %h", {phase_M[PW +: PW], signal_A[AW +: AW], signal_off[OW +: OW], signal_shape[3:2]},
               {16'd500, 12'd1000, 13'd2000, 2'd1}); else n_pass++;
    n_chk++; if ({phase_M[0 +: PW], signal_A[0 +: AW], signal_off[0 +: OW]} !== {16'd10, 12'd1200, 13'd0})
      $display("FAIL basic_ch0_untouched: got %h", {phase_M[0 +: PW], signal_A[0 +: AW], signal_off[0 +: OW]}); else n_pass++;
    cyc();
    n_chk++; if (update !== '0) $display("FAIL basic_update_one_cycle: got %b want 000", update); else n_pass++;
  endtask

  task automatic test_clamp();
    int t_amp[5], t_off[5], t_sh[5], x_amp[5], x_off[5], x_sh[5];
    logic x_err[5];
    t_amp = '{3000, 100, 20, 100, 4095}; t_off = '{2000, 5000, 10, 100, 0}; t_sh = '{1, 2, 3, 2, 0};
    x_amp = '{2095, 0, 20, 100, 4095};   x_off = '{2000, 4095, 10, 100, 0}; x_sh = '{1, 2, 0, 2, 0};
    x_err = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    sync_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_write(0, 1000 + i, t_amp[i], t_off[i], t_sh[i]);
      n_chk++; if (wr_err !== x_err[i]) $display("FAIL clamp_err case %0d: got %b want %b", i, wr_err, x_err[i]); else n_pass++;
      cyc();
      cyc();
      n_chk++; if ({update[0], signal_A[0 +: AW], signal_off[0 +: OW], signal_shape[1:0]} !== {1'b1, AW'(x_amp[i]), OW'(x_off[i]), 2'(x_sh[i])})
        $display("FAIL clamp_live case %0d: got amp=%0d off=%0d sh=%0d upd=%b want amp=%0d off=%0d sh=%0d upd=1", i,
                 signal_A[0 +: AW], signal_off[0 +: OW], signal_shape[1:0], update[0], x_amp[i], x_off[i], x_sh[i]); else n_pass++;
    end
    sync_en = 1'b1;
    cyc();
  endtask

  task automatic test_timeout();
    int k, n_up;
    sync_en = 1'b1;
    do_write(2, 77, 300, 400, 2);
    cyc();
    n_chk++; if (pending[2] !== 1'b1) $display("FAIL timeout_pending: got %b want 1", pending[2]); else n_pass++;
    k = 0;
    while (k < 40 && update[2] !== 1'b1) begin cyc(); k++; end
    n_chk++; if (k != TO) $display("FAIL timeout_latency: got %0d cycles want %0d", k, TO); else n_pass++;
    // Two writes to one channel, no wrap: only the second one goes live, once.
    do_write(0, 111, 222, 333, 2);
    repeat (3) cyc();
    do_write(0, 444, 555, 666, 1);
    n_up = 0;
    repeat (40) begin cyc(); if (update[0] === 1'b1) n_up++; end
    n_chk++; if (n_up != 1) $display("FAIL overwrite_update_count: got %0d want 1", n_up); else n_pass++;
    n_chk++; if ({phase_M[0 +: PW], signal_A[0 +: AW], signal_off[0 +: OW], signal_shape[1:0]} !== {16'd444, 12'd555, 13'd666, 2'd1})
      $display("FAIL overwrite_live: got %h", {phase_M[0 +: PW], signal_A[0 +: AW], signal_off[0 +: OW], signal_shape[1:0]}); else n_pass++;
  endtask

  task automatic test_bypass();
    int n_up;
    sync_en = 1'b1;
    // ch1 pending with old data; the next load coincides with a wrap.
    do_write(1, 900, 901, 902, 0);
    cyc();
    wr_valid = 1'b1; wr_ch = 2'd1; wr_phase = 16'd1234; wr_amp = 12'd345; wr_offset = 13'd456; wr_shape = 2'd2;
    cyc();
    wr_valid = 1'b0;
    phase_wrap = 3'b010;
    cyc();
    phase_wrap = '0;
    n_chk++; if ({update[1], pending[1]} !== 2'b10) $display("FAIL bypass_status: got %b want 10", {update[1], pending[1]}); else n_pass++;
    n_chk++; if ({phase_M[PW +: PW], signal_A[AW +: AW], signal_off[OW +: OW], signal_shape[3:2]} !== {16'd1234, 12'd345, 13'd456, 2'd2})
      $display("FAIL bypass_live: got %h", {phase_M[PW +: PW], signal_A[AW +: AW], signal_off[OW +: OW], signal_shape[3:2]}); else n_pass++;
    n_up = 0;
    repeat (TO + 4) begin cyc(); if (update[1] === 1'b1) n_up++; end
    n_chk++; if (n_up != 0) $display("FAIL bypass_no_second_update: got %0d want 0", n_up); else n_pass++;
    // Idle channel, load coinciding with commit_all.
    wr_valid = 1'b1; wr_ch = 2'd2; wr_phase = 16'd42; wr_amp = 12'd43; wr_offset = 13'd44; wr_shape = 2'd1;
    cyc();
    wr_valid = 1'b0;
    commit_all = 1'b1;
    cyc();
    commit_all = 1'b0;
    n_chk++; if ({update[2], pending[2], phase_M[2*PW +: PW]} !== {2'b10, 16'd42})
      $display("FAIL bypass_commit_all: got %h want %h", {update[2], pending[2], phase_M[2*PW +: PW]}, {2'b10, 16'd42}); else n_pass++;
    cyc();
  endtask

  task automatic test_back_to_back();
    int n_acc;
    sync_en = 1'b1;
    n_acc = 0;
    wr_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      n_chk++; if (wr_ready !== ((i % 2) == 0)) $display("FAIL b2b_ready cyc %0d: got %b want %b", i, wr_ready, (i % 2) == 0); else n_pass++;
      if (wr_ready === 1'b1) n_acc++;
      wr_ch = CHW'($urandom_range(0, NCH - 1)); wr_phase = PW'($urandom); wr_amp = AW'($urandom);
      wr_offset = OW'($urandom_range(0, 3000)); wr_shape = 2'($urandom_range(0, 2));
      cyc();
      n_chk++; if ({pending, update, wr_err, wr_ready} !== e_stat())
        $display("FAIL b2b_status cyc %0d: got %b want %b", i, {pending, update, wr_err, wr_ready}, e_stat()); else n_pass++;
    end
    wr_valid = 1'b0;
    n_chk++; if (n_acc != 6) $display("FAIL b2b_accept_count: got %0d want 6", n_acc); else n_pass++;
    cyc();
    commit_all = 1'b1;
    cyc();
    commit_all = 1'b0;
    n_chk++; if ({phase_M, signal_A, signal_off, signal_shape} !== e_live())
      $display("FAIL b2b_live: got %h want %h", {phase_M, signal_A, signal_off, signal_shape}, e_live()); else n_pass++;
    cyc();
  endtask

  task automatic test_bad_ch();
    int n_up;
    commit_all = 1'b1; cyc(); commit_all = 1'b0; cyc(); cyc();
    n_chk++; if (pending !== '0) $display("FAIL badch_pre_idle: got %b want 000", pending); else n_pass++;
    do_write(3, 5, 6, 7, 1);
    n_chk++; if (wr_err !== 1'b1) $display("FAIL badch_err: got %b want 1", wr_err); else n_pass++;
    n_up = 0;
    repeat (5) begin cyc(); if (update !== '0 || pending !== '0) n_up++; end
    n_chk++; if (n_up != 0) $display("FAIL badch_no_effect: got %0d busy cycles want 0", n_up); else n_pass++;
    n_chk++; if ({phase_M, signal_A, signal_off, signal_shape} !== e_live())
      $display("FAIL badch_live: got %h want %h", {phase_M, signal_A, signal_off, signal_shape}, e_live()); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      wr_valid = ($urandom_range(0, 1) == 1);
      wr_ch = CHW'($urandom_range(0, 3)); wr_phase = PW'($urandom);
      wr_amp = AW'($urandom); wr_offset = OW'($urandom_range(0, 8191)); wr_shape = 2'($urandom_range(0, 3));
      for (int c = 0; c < NCH; c++) phase_wrap[c] = ($urandom_range(0, 99) < 8);
      commit_all = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 3) sync_en = ~sync_en;
      cyc();
      n_chk++; if ({phase_M, signal_A, signal_off, signal_shape} !== e_live())
        $display("FAIL rand_live cyc %0d: got %h want %h", i, {phase_M, signal_A, signal_off, signal_shape}, e_live()); else n_pass++;
      n_chk++; if ({pending, update, wr_err, wr_ready} !== e_stat())
        $display("FAIL rand_status cyc %0d: got %b want %b", i, {pending, update, wr_err, wr_ready}, e_stat()); else n_pass++;
    end
    wr_valid = 1'b0; phase_wrap = '0; commit_all = 1'b0; sync_en = 1'b1;
    cyc(); cyc();
  endtask

  task automatic test_reset_mid();
    int n_up;
    sync_en = 1'b1;
    do_write(0, 321, 654, 987, 2);
    cyc();
    n_chk++; if (pending[0] !== 1'b1) $display("FAIL rstmid_pending: got %b want 1", pending[0]); else n_pass++;
    // A second write sits in the input register when reset hits.
    wr_valid = 1'b1; wr_ch = 2'd1; wr_phase = 16'd7; wr_amp = 12'd8; wr_offset = 13'd9; wr_shape = 2'd1;
    cyc();
    wr_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_chk++; if ({pending, wr_ready, wr_err} !== {{NCH{1'b0}}, 2'b10})
      $display("FAIL rstmid_status: got %b", {pending, wr_ready, wr_err}); else n_pass++;
    n_up = 0;
    repeat (TO + 4) begin cyc(); if (update !== '0 || pending !== '0) n_up++; end
    n_chk++; if (n_up != 0) $display("FAIL rstmid_no_update: got %0d busy cycles want 0", n_up); else n_pass++;
    n_chk++; if ({phase_M, signal_A, signal_off, signal_shape} !== {{NCH{16'd10}}, {NCH{12'd1200}}, {NCH*OW{1'b0}}, {NCH*2{1'b0}}})
      $display("FAIL rstmid_defaults: got %h", {phase_M, signal_A, signal_off, signal_shape}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_timeout();
    test_bypass();
    test_back_to_back();
    test_bad_ch();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
